forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit_pkg.sv | 30 +++
 rtl/forward_hazard_unit_fwd_select.sv | 32 +++
 rtl/forward_hazard_unit.sv | 104 ++++++++++
 tb/tb_forward_hazard_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / hazard unit:
// register-number width, operand select encodings and shadow stage layouts.
package forward_hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Control bits of a shadow stage; these are the only fields cleared by reset.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
  } stage_ctl_t;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] dest;
  } ex_dat_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Chooses the ALU operand source for one EX source register by matching it
// against the MEM and WB producers; the younger MEM producer wins.
module fwd_select
  import forward_hazard_unit_pkg::*;
(
  input  logic             i_src_used,
  input  logic [REG_W-1:0] i_src,
  input  logic             i_mem_valid,
  input  logic             i_mem_reg_write,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_wb_valid,
  input  logic             i_wb_reg_write,
  input  logic [REG_W-1:0] i_wb_dest,
  output fwd_sel_e         o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Register 0 is hard-wired, so a zero source never forwards.
  assign w_mem_hit = i_mem_valid && i_mem_reg_write && (i_mem_dest == i_src);
  assign w_wb_hit  = i_wb_valid  && i_wb_reg_write  && (i_wb_dest  == i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (i_src_used && (i_src != '0)) begin
      if (w_mem_hit)     o_sel = FWD_EXMEM;
      else if (w_wb_hit) o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Load-use stall detection and EX operand forwarding driven by a shadow
// EX/MEM/WB pipeline that tracks what the datapath holds each cycle.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  stage_ctl_t       r_ex_ctl;
  ex_dat_t          r_ex_dat;
  logic             r_mem_valid;
  logic             r_mem_reg_write;
  logic [REG_W-1:0] r_mem_dest;
  logic             r_wb_valid;
  logic             r_wb_reg_write;
  logic [REG_W-1:0] r_wb_dest;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_load_use;
  logic             w_bubble;
  fwd_sel_e         w_sel_a;
  fwd_sel_e         w_sel_b;

  // ID stage: a load in EX whose result the ID instruction needs cannot be forwarded yet.
  assign w_load_use = r_ex_ctl.valid && r_ex_ctl.mem_read && r_ex_ctl.reg_write &&
                      (r_ex_dat.dest != '0) &&
                      ((id_uses_rs && (id_rs == r_ex_dat.dest)) ||
                       (id_uses_rt && (id_rt == r_ex_dat.dest)));

  assign stall    = w_load_use && id_valid && !flush && !Rst;
  assign w_bubble = stall || flush || !id_valid;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ex_ctl        <= '0;
      r_mem_valid     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_stall_count   <= '0;
    end else begin
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_reg_write;
      r_mem_valid     <= r_ex_ctl.valid;
      r_mem_reg_write <= r_ex_ctl.reg_write;
      if (w_bubble) r_ex_ctl <= '0;
      else          r_ex_ctl <= '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read};
      if (stall && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // Register numbers ride along unreset; every consumer qualifies them with a valid bit.
  always_ff @(posedge Clk) begin
    r_ex_dat   <= '{rs: id_rs, rt: id_rt, uses_rs: id_uses_rs,
                    uses_rt: id_uses_rt, dest: id_dest};
    r_mem_dest <= r_ex_dat.dest;
    r_wb_dest  <= r_mem_dest;
  end

  // EX stage: operand selects come from registered state only.
  fwd_select u_fwd_a (
    .i_src_used      (r_ex_ctl.valid && r_ex_dat.uses_rs),
    .i_src           (r_ex_dat.rs),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_dest      (r_mem_dest),
    .i_wb_valid      (r_wb_valid),
    .i_wb_reg_write  (r_wb_reg_write),
    .i_wb_dest       (r_wb_dest),
    .o_sel           (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_src_used      (r_ex_ctl.valid && r_ex_dat.uses_rt),
    .i_src           (r_ex_dat.rt),
    .i_mem_valid     (r_mem_valid),
    .i_mem_reg_write (r_mem_reg_write),
    .i_mem_dest      (r_mem_dest),
    .i_wb_valid      (r_wb_valid),
    .i_wb_reg_write  (r_wb_reg_write),
    .i_wb_dest       (r_wb_dest),
    .o_sel           (w_sel_b)
  );

  assign fwd_a_sel   = Rst ? 2'd0 : w_sel_a;
  assign fwd_b_sel   = Rst ? 2'd0 : w_sel_b;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed hazard scenarios plus a random
// instruction stream, checked against an instruction-history reference model.
module tb_forward_hazard_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  forward_hazard_unit dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_count  (stall_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit valid;
    int rs;
    int rt;
    bit urs;
    bit urt;
    int dest;
    bit rw;
    bit mr;
  } ins_t;

  // hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
  ins_t hist[3];
  int   m_count;
  int   n_tests = 0;
  int   n_fail  = 0;

  ins_t cur_id;
  bit   cur_fl, cur_rst, cur_stall;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr);
    ins_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.dest = dest; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic ins_t lw(int dest, int base);
    return mk(1'b1, base, 0, 1'b1, 1'b0, dest, 1'b1, 1'b1);
  endfunction

  function automatic ins_t alu(int rd, int rs, int rt);
    return mk(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  function automatic ins_t nop();
    return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endfunction

  // Which older instruction supplies register r for the EX instruction:
  // 1 if the one right behind it (MEM), 2 if two behind (WB), 0 for the register file.
  function automatic int exp_sel(int r, bit used);
    if (!hist[0].valid || !used || r == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (hist[k].valid && hist[k].rw && hist[k].dest == r) return k;
    return 0;
  endfunction

  function automatic bit exp_stall(ins_t id, bit fl, bit rst);
    if (rst || fl || !id.valid) return 1'b0;
    if (!(hist[0].valid && hist[0].mr && hist[0].rw && hist[0].dest != 0)) return 1'b0;
    return (id.urs && id.rs == hist[0].dest) || (id.urt && id.rt == hist[0].dest);
  endfunction

  task automatic drive(input ins_t id, input bit fl, input bit rst);
    @(negedge Clk);
    Rst          = rst;
    id_valid     = id.valid;
    id_rs        = 5'(id.rs);
    id_rt        = 5'(id.rt);
    id_uses_rs   = id.urs;
    id_uses_rt   = id.urt;
    id_dest      = 5'(id.dest);
    id_reg_write = id.rw;
    id_mem_read  = id.mr;
    flush        = fl;
    #1;
    cur_stall = exp_stall(id, fl, rst);
    chk("stall", int'(stall), int'(cur_stall));
    chk("fwd_a", int'(fwd_a_sel), rst ? 0 : exp_sel(hist[0].rs, hist[0].urs));
    chk("fwd_b", int'(fwd_b_sel), rst ? 0 : exp_sel(hist[0].rt, hist[0].urt));
    chk("stall_count", int'(stall_count), m_count);
    cur_id  = id;
    cur_fl  = fl;
    cur_rst = rst;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (cur_rst) begin
      for (int k = 0; k < 3; k++) hist[k] = nop();
      m_count = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (cur_stall || cur_fl || !cur_id.valid) ? nop() : cur_id;
      if (cur_stall && m_count < 65535) m_count++;
    end
    #1;
  endtask

  task automatic step(input ins_t id);
    drive(id, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(nop(), 1'b0, 1'b1);
    tick();
    drive(nop(), 1'b0, 1'b1);
    tick();
  endtask

  function automatic ins_t rand_ins();
    ins_t t;
    t.valid = ($urandom_range(9) != 0);
    t.rs    = int'($urandom_range(3));
    t.rt    = int'($urandom_range(3));
    t.urs   = 1'($urandom_range(1));
    t.urt   = 1'($urandom_range(1));
    t.dest  = int'($urandom_range(3));
    t.mr    = ($urandom_range(9) < 3);
    t.rw    = t.mr || ($urandom_range(9) < 8);
    return t;
  endfunction

  initial begin
    ins_t cur;
    bit   fl, rst;
    for (int k = 0; k < 3; k++) hist[k] = nop();
    m_count = 0;
    Rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge Clk);

    // lw $8 ; add $9,$8,$10 -> one stall cycle, then MEM/WB forwarding on A
    do_reset();
    step(lw(8, 1));
    drive(alu(9, 8, 10), 1'b0, 1'b0);
    chk("ldu_stall_on", int'(stall), 1);
    tick();
    drive(alu(9, 8, 10), 1'b0, 1'b0);
    chk("ldu_stall_off", int'(stall), 0);
    chk("ldu_count", int'(stall_count), 1);
    tick();
    drive(nop(), 1'b0, 1'b0);
    chk("ldu_fwd_a", int'(fwd_a_sel), 2);
    tick();

    // add $8 ; sub $11,$10,$8 -> EX/MEM on B
    do_reset();
    step(alu(8, 1, 2));
    drive(alu(11, 10, 8), 1'b0, 1'b0);
    chk("exmem_b_stall", int'(stall), 0);
    tick();
    drive(nop(), 1'b0, 1'b0);
    chk("exmem_b_sel", int'(fwd_b_sel), 1);
    chk("exmem_b_a", int'(fwd_a_sel), 0);
    tick();

    // add $8 ; add $8 ; or $12,$8,$8 -> youngest producer wins on both
    do_reset();
    step(alu(8, 1, 2));
    step(alu(8, 3, 4));
    step(alu(12, 8, 8));
    drive(nop(), 1'b0, 1'b0);
    chk("youngest_a", int'(fwd_a_sel), 1);
    chk("youngest_b", int'(fwd_b_sel), 1);
    tick();

    // lw $0 ; add $9,$0,$0 -> no stall, no forwarding
    do_reset();
    step(lw(0, 1));
    drive(alu(9, 0, 0), 1'b0, 1'b0);
    chk("r0_stall", int'(stall), 0);
    tick();
    drive(nop(), 1'b0, 1'b0);
    chk("r0_a", int'(fwd_a_sel), 0);
    chk("r0_b", int'(fwd_b_sel), 0);
    tick();

    // lw $8 ; flushed dependent add -> no stall, bubble in EX
    do_reset();
    step(lw(8, 1));
    drive(alu(9, 8, 10), 1'b1, 1'b0);
    chk("flush_stall", int'(stall), 0);
    tick();
    drive(nop(), 1'b0, 1'b0);
    chk("flush_a", int'(fwd_a_sel), 0);
    chk("flush_b", int'(fwd_b_sel), 0);
    tick();

    // reset arriving during a load-use stall
    do_reset();
    step(lw(8, 1));
    step(alu(9, 8, 10));
    step(alu(9, 8, 10));
    step(lw(8, 2));
    drive(alu(9, 8, 10), 1'b0, 1'b1);
    chk("rst_stall", int'(stall), 0);
    tick();
    drive(alu(9, 8, 10), 1'b0, 1'b0);
    chk("rst_stall_after", int'(stall), 0);
    chk("rst_count", int'(stall_count), 0);
    chk("rst_a", int'(fwd_a_sel), 0);
    tick();
    drive(nop(), 1'b0, 1'b0);
    chk("rst_a_next", int'(fwd_a_sel), 0);
    chk("rst_b_next", int'(fwd_b_sel), 0);
    tick();

    // random stream: a stalled instruction stays in ID until it issues
    do_reset();
    cur = rand_ins();
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(9) == 0);
      rst = ($urandom_range(199) == 0);
      drive(cur, fl, rst);
      tick();
      if (!cur_stall) cur = rand_ins();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
